// File: rtl/wave_packetizer_if.sv
// Byte-stream interface between the packetizer and the UDP TX stage.
// master drives data, valid and the sop/eop markers; slave returns ready.
interface wave_packetizer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_sop;
    logic       tx_eop;

    modport master (output tx_data, tx_valid, tx_sop, tx_eop, input tx_ready);
    modport slave  (input tx_data, tx_valid, tx_sop, tx_eop, output tx_ready);
endinterface

// File: rtl/wave_packetizer.sv
// Walks the ADC handler's waveform buffer and emits header + big-endian samples as a byte stream.
// Optional trailer checksum is built when WAVE_PKT_CHECKSUM_EN is defined.
module wave_packetizer #(
    parameter int          MAX_SAMPLES = 1000,
    parameter int          RD_LAT      = 2,
    parameter logic [15:0] MAGIC       = 16'hA55A
) (
    input  logic                      sys_clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [15:0]               num_samples,
    output logic [15:0]               sample_num,
    input  logic [15:0]               wave_sample,
    wave_packetizer_if.master         tx,
    output logic                      busy,
    output logic                      done
);

`ifdef WAVE_PKT_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, ADDR, WAIT, S_HI, S_LO, TRL, FIN} state_t;
    localparam state_t AFTER = TRL;
    localparam logic   CK_EN = 1'b1;
`else
    typedef enum logic [2:0] {IDLE, HDR, ADDR, WAIT, S_HI, S_LO, FIN} state_t;
    localparam state_t AFTER = FIN;
    localparam logic   CK_EN = 1'b0;
`endif

    localparam logic [15:0] MAX_CNT = 16'(MAX_SAMPLES);
    localparam logic [3:0]  RD_W    = 4'(RD_LAT);

    state_t      state, nxt;
    logic [2:0]  bidx;
    logic [15:0] idx, cnt, seq, hold;
    logic [3:0]  wcnt;
    logic        last;
`ifdef WAVE_PKT_CHECKSUM_EN
    logic [15:0] sum;
`endif

    assign last = (idx == cnt - 16'd1);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt         = state;
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;
        tx.tx_sop   = 1'b0;
        tx.tx_eop   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) nxt = HDR;
            end
            HDR: begin
                tx.tx_valid = 1'b1;
                case (bidx)
                    3'd0:    tx.tx_data = MAGIC[15:8];
                    3'd1:    tx.tx_data = MAGIC[7:0];
                    3'd2:    tx.tx_data = seq[15:8];
                    3'd3:    tx.tx_data = seq[7:0];
                    3'd4:    tx.tx_data = cnt[15:8];
                    default: tx.tx_data = cnt[7:0];
                endcase
                tx.tx_sop = (bidx == 3'd0);
                tx.tx_eop = (bidx == 3'd5) && (cnt == 16'd0) && !CK_EN;
                if (tx.tx_ready && bidx == 3'd5) nxt = (cnt == 16'd0) ? AFTER : ADDR;
            end
            ADDR: nxt = WAIT;
            WAIT: if (wcnt == RD_W) nxt = S_HI;
            S_HI: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = hold[15:8];
                if (tx.tx_ready) nxt = S_LO;
            end
            S_LO: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = hold[7:0];
                tx.tx_eop   = last && !CK_EN;
                if (tx.tx_ready) nxt = last ? AFTER : ADDR;
            end
`ifdef WAVE_PKT_CHECKSUM_EN
            TRL: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = bidx[0] ? sum[7:0] : sum[15:8];
                tx.tx_eop   = bidx[0];
                if (tx.tx_ready && bidx[0]) nxt = FIN;
            end
`endif
            FIN: begin
                busy = 1'b0;
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            bidx       <= '0;
            idx        <= '0;
            cnt        <= '0;
            seq        <= '0;
            hold       <= '0;
            wcnt       <= '0;
            sample_num <= '0;
`ifdef WAVE_PKT_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt  <= (num_samples > MAX_CNT) ? MAX_CNT : num_samples;
                    bidx <= '0;
`ifdef WAVE_PKT_CHECKSUM_EN
                    sum  <= '0;
`endif
                end
                HDR: if (tx.tx_ready) begin
                    if (bidx == 3'd5) begin
                        bidx <= '0;
                        idx  <= '0;
                    end else begin
                        bidx <= bidx + 3'd1;
                    end
                end
                ADDR: begin
                    sample_num <= idx;
                    wcnt       <= '0;
                end
                // The handler's read path needs RD_LAT edges after sample_num moves.
                WAIT: begin
                    wcnt <= wcnt + 4'd1;
                    if (wcnt == RD_W) begin
                        hold <= wave_sample;
`ifdef WAVE_PKT_CHECKSUM_EN
                        sum  <= sum + wave_sample;
`endif
                    end
                end
                S_LO: if (tx.tx_ready && !last) idx <= idx + 16'd1;
`ifdef WAVE_PKT_CHECKSUM_EN
                TRL: if (tx.tx_ready) bidx <= bidx + 3'd1;
`endif
                FIN: seq <= seq + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_packetizer.sv
// Scoreboard bench for wave_packetizer: stimulus queues expected bytes, a monitor pops and compares.
module tb_wave_packetizer;
    localparam int RD_LAT = 2;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_samples = 16'd0;
    logic [15:0] sample_num;
    logic [15:0] wave_sample;
    logic        busy, done;

    wave_packetizer_if tx();

    wave_packetizer #(.MAX_SAMPLES(1000), .RD_LAT(RD_LAT), .MAGIC(16'hA55A)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .start(start), .num_samples(num_samples),
        .sample_num(sample_num), .wave_sample(wave_sample), .tx(tx.master),
        .busy(busy), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    // Handler model: registered read path, RD_LAT stages deep.
    logic [15:0] hpipe [RD_LAT];
    logic        special = 1'b0;
    always @(posedge sys_clk) begin
        hpipe[0] <= sample_num;
        for (int i = 1; i < RD_LAT; i++) hpipe[i] <= hpipe[i-1];
    end
    assign wave_sample = special ? (hpipe[RD_LAT-1][0] ? 16'h0002 : 16'hFFFF)
                                 : 16'h1000 + hpipe[RD_LAT-1];

    typedef struct packed {logic [7:0] d; logic sop; logic eop;} exp_t;
    exp_t q[$];
    int checks = 0, failures = 0, done_cnt = 0;
    logic [15:0] seq_m = 16'd0;
    logic rdy_mode = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] smp(input int i);
        logic [31:0] iv;
        iv = 32'(i);
        if (special) return iv[0] ? 16'h0002 : 16'hFFFF;
        return 16'h1000 + iv[15:0];
    endfunction

    task automatic push_pkt(input logic [15:0] sq, input logic [15:0] n);
        logic [7:0]  b[$];
        logic [15:0] c, s, sum;
        c   = (n > 16'd1000) ? 16'd1000 : n;
        sum = 16'd0;
        b.push_back(8'hA5); b.push_back(8'h5A);
        b.push_back(sq[15:8]); b.push_back(sq[7:0]);
        b.push_back(c[15:8]); b.push_back(c[7:0]);
        for (int i = 0; i < int'(c); i++) begin
            s = smp(i);
            sum = sum + s;
            b.push_back(s[15:8]); b.push_back(s[7:0]);
        end
`ifdef WAVE_PKT_CHECKSUM_EN
        b.push_back(sum[15:8]); b.push_back(sum[7:0]);
`endif
        for (int k = 0; k < b.size(); k++)
            q.push_back('{d: b[k], sop: (k == 0), eop: (k == b.size() - 1)});
    endtask

    // tx_ready changes just after the rising edge so the monitor sees it stable.
    initial begin
        int ph;
        logic [3:0] pat;
        ph = 0;
        pat = 4'b1001;
        tx.tx_ready = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            if (rdy_mode) begin
                tx.tx_ready = pat[3 - ph];
                ph = (ph + 1) % 4;
            end else begin
                tx.tx_ready = 1'b1;
                ph = 0;
            end
        end
    end

    initial begin
        logic stalled;
        logic [9:0] held;
        exp_t e;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge sys_clk);
            if (!reset_n) begin
                stalled = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (stalled)
                    chk("stall_hold", {21'd0, tx.tx_valid, tx.tx_data, tx.tx_sop, tx.tx_eop},
                        {21'd0, 1'b1, held});
                if (tx.tx_valid && tx.tx_ready) begin
                    stalled = 1'b0;
                    if (q.size() == 0) begin
                        chk("unexpected_byte", {22'd0, tx.tx_data, tx.tx_sop, tx.tx_eop}, 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        chk("byte", {22'd0, tx.tx_data, tx.tx_sop, tx.tx_eop}, {22'd0, e});
                    end
                end else if (tx.tx_valid) begin
                    stalled = 1'b1;
                    held = {tx.tx_data, tx.tx_sop, tx.tx_eop};
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    task automatic run_pkt(input logic [15:0] n, input logic mid_start);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 0;
        push_pkt(seq_m, n);
        @(negedge sys_clk);
        start = 1'b1;
        num_samples = n;
        @(negedge sys_clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        if (mid_start) begin
            repeat (4) @(negedge sys_clk);
            start = 1'b1;
            num_samples = 16'd7;
            @(negedge sys_clk);
            start = 1'b0;
        end
        for (int k = 0; k < 30000 && !seen; k++) begin
            @(negedge sys_clk);
            if (done_cnt != d0) seen = 1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        repeat (20) @(negedge sys_clk);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        seq_m = seq_m + 16'd1;
    endtask

    initial begin
        logic [15:0] sn;
        bit seen;
        repeat (3) @(negedge sys_clk);
        chk("reset_outs", {19'd0, tx.tx_valid, busy, done, tx.tx_sop, tx.tx_eop, tx.tx_data}, 32'd0);
        chk("reset_sample_num", {16'd0, sample_num}, 32'd0);
        reset_n = 1'b1;

        // 1: A5 5A 00 00 00 03 10 00 10 01 10 02
        run_pkt(16'd3, 1'b0);
        chk("t1_sample_num", {16'd0, sample_num}, 32'd2);

        // 2: same bytes under 1,0,0,1 backpressure
        rdy_mode = 1'b1;
        run_pkt(16'd3, 1'b0);
        rdy_mode = 1'b0;

        // 3: header-only packets, sequence advances, sample_num untouched
        sn = sample_num;
        run_pkt(16'd0, 1'b0);
        run_pkt(16'd0, 1'b0);
        chk("t3_sample_num", {16'd0, sample_num}, {16'd0, sn});

        // 4: 1200 clamps to 1000 (03 E8)
        run_pkt(16'd1200, 1'b0);
        chk("t4_last_sample_num", {16'd0, sample_num}, 32'd999);

        // 5a: start while busy is ignored
        run_pkt(16'd2, 1'b1);

        // 5b: reset mid-sample, then sequence restarts at 0
        push_pkt(seq_m, 16'd3);
        @(negedge sys_clk);
        start = 1'b1;
        num_samples = 16'd3;
        @(negedge sys_clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge sys_clk);
            if (sample_num == 16'd1) seen = 1;
        end
        if (!seen) chk("t5_wait_timeout", 32'd0, 32'd1);
        @(posedge sys_clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_clear", {19'd0, tx.tx_valid, busy, done, tx.tx_sop, tx.tx_eop, tx.tx_data}, 32'd0);
        chk("t5_sample_num_clear", {16'd0, sample_num}, 32'd0);
        q.delete();
        seq_m = 16'd0;
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
        run_pkt(16'd2, 1'b0);

`ifdef WAVE_PKT_CHECKSUM_EN
        // 6: FFFF + 0002 -> trailer 00 01
        special = 1'b1;
        run_pkt(16'd2, 1'b0);
        special = 1'b0;
`endif

        chk("final_queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wave_packetizer.md
Name: wave_packetizer

Overview:
- Downstream consumer of the ADC capture handler.
- Once an acquisition is ready, it steps the handler's sample-number input through the captured waveform and reads back each 16-bit waveSample.
- It serialises header, samples and optional trailer into an 8-bit valid/ready byte stream with start/end markers for the Ethernet UDP TX stage.
- One packet per start request.

Parameters:
- MAX_SAMPLES, 1000: waveform buffer depth; larger requested counts are clamped to this.
- RD_LAT, 2: cycles from a sample_num change to a valid wave_sample, covering the handler's registered read path (range 1-15).
- MAGIC, 16'hA55A: packet header marker.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to packetise the current waveform.
- num_samples  in  16  samples to send; sampled on an accepted start.
- sample_num  out  16  sample index driven to the ADC handler.
- wave_sample  in  16  sample returned by the handler, valid RD_LAT cycles after sample_num changes.
- tx_data  out  8  stream byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts the byte when tx_valid && tx_ready.
- tx_sop  out  1  high with the first byte of a packet.
- tx_eop  out  1  high with the last byte of a packet.
- busy  out  1  high from an accepted start until the final byte transfers.
- done  out  1  one-cycle pulse the cycle after the final byte transfers.

Behaviour:
- Reset (asynchronous, immediate, also mid-packet): all outputs 0, sequence counter 0, state IDLE. No partial-packet recovery; the downstream side must discard a packet that has no eop.
- States: IDLE, HDR, ADDR, WAIT, S_HI, S_LO, TRL (TRL only with the optional feature), FIN.
- IDLE: start==1 is accepted.
  - Latch cnt = min(num_samples, MAX_SAMPLES).
  - Go to HDR.
  - busy=1 the next cycle.
  - The first header byte is presented on tx_valid in the cycle after start.
- HDR: six bytes, in order: MAGIC[15:8], MAGIC[7:0], seq[15:8], seq[7:0], cnt[15:8], cnt[7:0].
  - tx_sop=1 on byte 0 only.
  - Byte index advances only on a transfer.
  - After byte 5 transfers: if cnt==0, go to FIN (or TRL). Otherwise set idx=0 and go to ADDR.
- ADDR: drive sample_num=idx, clear the wait counter, go to WAIT.
- WAIT: count RD_LAT cycles, then latch wave_sample into a holding register and go to S_HI.
- S_HI: send sample[15:8]; on transfer go to S_LO.
- S_LO: send sample[7:0]. On transfer:
  - if idx==cnt-1, go to FIN (or TRL);
  - otherwise idx+1, go to ADDR.
- tx_eop rules:
  - asserted on the S_LO byte of the last sample, or on header byte 5 when cnt==0;
  - without the feature, on the final byte overall.
- FIN: done=1 for one cycle, busy=0, seq increments by 1 (wraps 0xFFFF->0x0000), return to IDLE. tx_valid=0 in FIN.
- Handshake:
  - While tx_valid && !tx_ready, tx_data, tx_sop and tx_eop hold stable.
  - tx_valid never deasserts until the byte transfers.
  - tx_valid is 0 in IDLE, ADDR, WAIT and FIN.
- sample_num holds its last value between packets and is not reset to 0 by the FSM (reset only via reset_n).
- start while busy (including in FIN) is ignored, not queued.
- Byte order is big-endian throughout. Samples pass through unmodified (the 14-bit ADC value zero-extended by the handler).

Optional Feature:
- Macro: WAVE_PKT_CHECKSUM_EN.
- Defined:
  - a 16-bit accumulator, cleared on an accepted start, adds each latched sample modulo 2^16;
  - TRL sends sum[15:8] then sum[7:0];
  - tx_eop moves to sum[7:0];
  - packet length = 6 + 2*cnt + 2.
- Undefined: the TRL state and accumulator are absent; packet length = 6 + 2*cnt.

Test Plan:
1. Reset, tx_ready=1, handler model returns 0x1000+index, num_samples=3, start:
   - bytes A5 5A 00 00 00 03 10 00 10 01 10 02;
   - sop on A5, eop on 02;
   - done pulses once; busy drops.
2. Same packet, with tx_ready toggled 1,0,0,1 repeating: identical byte sequence; tx_data held stable through every stalled cycle; no byte lost or duplicated.
3. num_samples=0:
   - six header bytes only, eop on the 6th;
   - sample_num unchanged;
   - second packet header carries seq=0x0001.
4. num_samples=1200: header count bytes 03 E8; exactly 1000 samples sent; last sample_num=999.
5. start asserted mid-packet, then reset_n pulled low mid-sample:
   - the mid-packet start has no effect;
   - on reset, outputs clear asynchronously;
   - the next packet header carries seq=0x0000.
6. WAVE_PKT_CHECKSUM_EN defined, samples 0xFFFF and 0x0002: trailer bytes 00 01; eop on the final 01.
